flp_complex_packer: RTL

Sits directly downstream of the integer-to-double converter in the CKKS decode path. Consumes one stream of N double-precision coefficients per polynomial and pairs coefficient j (real part) with coefficient j+N/2 (imag part). Emits N/2 complex words to the FFT input.
- First half of each frame is buffered internally.
- The pair is emitted as each second-half coefficient arrives.

---
 rtl/flp_complex_packer.sv | 104 ++++++++++
 1 files changed

// File: rtl/flp_complex_packer.sv
// Pairs coefficient j with coefficient j+N/2 of each CKKS frame into one complex word for the FFT.
// Build option PACKER_CONJUGATE_EN: emit the complex conjugate (imag sign flipped unless zero/subnormal).
`ifndef OVERALL_BITS
`define OVERALL_BITS 64
`endif

module flp_complex_packer #(
   parameter int LOGN = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [`OVERALL_BITS-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [`OVERALL_BITS-1:0] out_real,
   output logic [`OVERALL_BITS-1:0] out_imag,
   output logic [LOGN-2:0]          out_index,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     frame_done
);

   localparam int W     = `OVERALL_BITS;
   localparam int IW    = LOGN - 1;
   localparam int DEPTH = 1 << IW;
   localparam logic [IW-1:0] LAST = '1;

   localparam logic ST_FILL = 1'b0;
   localparam logic ST_PAIR = 1'b1;

   logic          state;
   logic [IW-1:0] wr_cnt;
   logic [IW-1:0] rd_cnt;
   logic [W-1:0]  pair_buf [DEPTH];
   logic          accept;
   logic          out_fire;
   logic [W-1:0]  imag_next;

   // FILL never waits on the output register: the previous frame's last pair is already registered.
   assign in_ready = (state == ST_FILL) || !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

`ifdef PACKER_CONJUGATE_EN
   localparam int EXP_W = 11;

   always_comb begin
      imag_next = in_data;
      if (in_data[W-2 -: EXP_W] != '0) begin
         imag_next[W-1] = ~in_data[W-1];
      end
   end
`else
   assign imag_next = in_data;
`endif

   // First-half storage; contents need no reset because FILL always overwrites before PAIR reads.
   always_ff @(posedge clk) begin
      if (state == ST_FILL && accept) begin
         pair_buf[wr_cnt] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_FILL;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         out_valid  <= 1'b0;
         out_real   <= '0;
         out_imag   <= '0;
         out_index  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= out_fire && (out_index == LAST);

         if (state == ST_FILL) begin
            if (accept) begin
               wr_cnt <= wr_cnt + 1'b1;
               if (wr_cnt == LAST) begin
                  state <= ST_PAIR;
               end
            end
            if (out_fire) begin
               out_valid <= 1'b0;
            end
         end else begin
            if (accept) begin
               out_real  <= pair_buf[rd_cnt];
               out_imag  <= imag_next;
               out_index <= rd_cnt;
               out_valid <= 1'b1;
               rd_cnt    <= rd_cnt + 1'b1;
               if (rd_cnt == LAST) begin
                  state <= ST_FILL;
               end
            end else if (out_fire) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule
